// File: rtl/axi4lite_pkg.sv
// Shared response codes, read-FSM states and width helpers for the AXI4-Lite slave memory.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int lane_shift(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axi4lite_mem_array.sv
// DEPTH x DATA_W RAM with a byte-enabled write port and a registered read-first read port.
module axi4lite_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Byte-lane write; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Registered read; sees pre-write contents when colliding with a write.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/axi4lite_slave_mem.sv
// AXI4-Lite slave memory: independent AW/W holding slots, byte-strobe writes,
// range decode with SLVERR and a read FSM with programmable wait states.
module axi4lite_slave_mem
    import axi4lite_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 32,
    parameter int              DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              RD_WAIT   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = idx_width(DEPTH);
    localparam int OFF_W  = lane_shift(DATA_W);

    // Returns {out_of_range, word_index}.
    function automatic logic [IDX_W:0] decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] word;
        word   = (addr - BASE_ADDR) >> OFF_W;
        decode = {(addr < BASE_ADDR) || (word >= ADDR_W'(DEPTH)), word[IDX_W-1:0]};
    endfunction

    logic              en_q;
    logic              aw_full_q, aw_oor_q, w_full_q;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    rd_state_e         rd_state_q, rd_state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  rd_idx_q;
    logic              rd_oor_q;
    logic [1:0]        rresp_q;
    logic              rd_re_s;
    logic [DATA_W-1:0] mem_rdata_s;
    logic              aw_hs_s, w_hs_s, ar_hs_s, commit_s;

    // Readies are held low until the first edge after reset is released.
    assign awready  = en_q && !aw_full_q;
    assign wready   = en_q && !w_full_q;
    assign arready  = en_q && (rd_state_q == R_IDLE);
    assign aw_hs_s  = awvalid && awready;
    assign w_hs_s   = wvalid && wready;
    assign ar_hs_s  = arvalid && arready;
    assign commit_s = aw_full_q && w_full_q && !bvalid_q;

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign rvalid = (rd_state_q == R_RESP);
    assign rresp  = rresp_q;
    assign rdata  = (rd_state_q == R_RESP && !rd_oor_q) ? mem_rdata_s : '0;

    // Write slots and B channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q      <= 1'b0;
            aw_full_q <= 1'b0;
            aw_oor_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            en_q <= 1'b1;
            if (aw_hs_s) begin
                aw_full_q            <= 1'b1;
                {aw_oor_q, aw_idx_q} <= decode(awaddr);
            end else if (commit_s) begin
                aw_full_q <= 1'b0;
            end
            if (w_hs_s) begin
                w_full_q <= 1'b1;
                wdata_q  <= wdata;
                wstrb_q  <= wstrb;
            end else if (commit_s) begin
                w_full_q <= 1'b0;
            end
            if (commit_s) begin
                bvalid_q <= 1'b1;
                bresp_q  <= aw_oor_q ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read FSM state, wait counter and latched request.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            cnt_q      <= 4'd0;
            rd_idx_q   <= '0;
            rd_oor_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            cnt_q      <= cnt_d;
            if (ar_hs_s) begin
                {rd_oor_q, rd_idx_q} <= decode(araddr);
            end
            if (rd_re_s) begin
                rresp_q <= rd_oor_q ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // The cycle after AR is always spent in R_WAIT so the RAM sees the latched index.
    always_comb begin
        rd_state_d = rd_state_q;
        cnt_d      = cnt_q;
        rd_re_s    = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_d = R_WAIT;
                    cnt_d      = 4'(RD_WAIT);
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rd_state_d = R_RESP;
                    rd_re_s    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rd_state_d = R_IDLE;
                end else begin
                    rd_state_d = R_RESP;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase
    end

    axi4lite_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (commit_s && !aw_oor_q && !reset),
        .waddr_i (aw_idx_q),
        .wstrb_i (wstrb_q),
        .wdata_i (wdata_q),
        .re_i    (rd_re_s),
        .raddr_i (rd_idx_q),
        .rdata_o (mem_rdata_s)
    );

endmodule

// File: tb/tb_axi4lite_slave_mem.sv
// Scoreboard bench for axi4lite_slave_mem: directed timing scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_axi4lite_slave_mem;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 64;
    localparam int          RDW   = 3;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [DW-1:0] wdata = '0, rdata;
    logic [3:0]    wstrb = '0;
    logic [1:0]    bresp, rresp;

    int checks = 0;
    int errors = 0;

    logic [1:0]  exp_b[$];
    logic [31:0] exp_rdata[$];
    logic [1:0]  exp_rresp[$];
    logic [31:0] model_mem [DEPTH];

    axi4lite_slave_mem #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_WAIT(RDW)
    ) dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual=no handshake expected=handshake within bound", name);
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < DEPTH);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int w;
        if (in_range(a)) begin
            w = int'((a - BASE) >> 2);
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
            end
            exp_b.push_back(2'b00);
        end else begin
            exp_b.push_back(2'b10);
        end
    endtask

    task automatic model_read(input logic [31:0] a);
        if (in_range(a)) begin
            exp_rdata.push_back(model_mem[int'((a - BASE) >> 2)]);
            exp_rresp.push_back(2'b00);
        end else begin
            exp_rdata.push_back(32'h0);
            exp_rresp.push_back(2'b10);
        end
    endtask

    task automatic send_aw(input logic [31:0] a);
        bit got = 1'b0;
        awaddr  = a;
        awvalid = 1'b1;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            got = awready;
        end
        if (!got) timeout("aw_handshake");
        @(posedge clk);
        #1 awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit got = 1'b0;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            got = wready;
        end
        if (!got) timeout("w_handshake");
        @(posedge clk);
        #1 wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit got = 1'b0;
        araddr  = a;
        arvalid = 1'b1;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            got = arready;
        end
        if (!got) timeout("ar_handshake");
        @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    task automatic take_b(input int dly);
        bit got = 1'b0;
        repeat (dly) @(posedge clk);
        #1 bready = 1'b1;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            got = bvalid;
        end
        if (!got) timeout("b_response");
        @(posedge clk);
        #1 bready = 1'b0;
    endtask

    task automatic take_r(input int dly);
        bit got = 1'b0;
        repeat (dly) @(posedge clk);
        #1 rready = 1'b1;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            got = rvalid;
        end
        if (!got) timeout("r_response");
        @(posedge clk);
        #1 rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly);
        model_write(a, d, s);
        fork
            begin repeat (aw_dly) @(posedge clk); #1; send_aw(a); end
            begin repeat (w_dly) @(posedge clk); #1; send_w(d, s); end
        join
        take_b(b_dly);
    endtask

    task automatic do_read(input logic [31:0] a, input int ar_dly, input int r_dly);
        model_read(a);
        repeat (ar_dly) @(posedge clk);
        #1;
        send_ar(a);
        take_r(r_dly);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks VALID/payload hold while stalled.
    initial begin
        logic        pbv = 1'b0, pbh = 1'b0, prv = 1'b0, prh = 1'b0;
        logic [1:0]  pbr = 2'b00, prr = 2'b00;
        logic [31:0] prd = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pbv = 1'b0;
                prv = 1'b0;
            end else begin
                if (pbv && !pbh) begin
                    chk("bvalid_held", bvalid, 1);
                    chk("bresp_held", bresp, pbr);
                end
                if (prv && !prh) begin
                    chk("rvalid_held", rvalid, 1);
                    chk("rdata_held", rdata, prd);
                    chk("rresp_held", rresp, prr);
                end
                if (bvalid && bready) begin
                    if (exp_b.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL stray_b: actual=bresp %0h expected=no response", bresp);
                    end else begin
                        chk("bresp", bresp, exp_b.pop_front());
                    end
                end
                if (rvalid && rready) begin
                    if (exp_rdata.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL stray_r: actual=rdata %0h expected=no response", rdata);
                    end else begin
                        chk("rdata", rdata, exp_rdata.pop_front());
                        chk("rresp", rresp, exp_rresp.pop_front());
                    end
                end
                pbv = bvalid; pbh = bvalid && bready; pbr = bresp;
                prv = rvalid; prh = rvalid && rready; prr = rresp; prd = rdata;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d1, d2, old44;

        // Reset state and ready release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rel_awready", awready, 1);
        chk("rel_wready", wready, 1);
        chk("rel_arready", arready, 1);
        @(posedge clk);
        #1;

        for (int w = 0; w < DEPTH; w++) begin
            do_write(BASE + 32'(w * 4), $urandom, 4'hF, 0, 0, 0);
        end

        // AW at edge 0, W at edge 3: bvalid must appear only after edge 4.
        model_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        awaddr  = BASE + 32'h10;
        awvalid = 1'b1;
        @(negedge clk);
        chk("t1_awready", awready, 1);
        @(posedge clk);
        #1 awvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wdata  = 32'hDEAD_BEEF;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        @(negedge clk);
        chk("t1_wready", wready, 1);
        @(posedge clk);
        #1 wvalid = 1'b0;
        @(negedge clk);
        chk("t1_bvalid_edge3", bvalid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("t1_bvalid_edge4", bvalid, 1);
        @(posedge clk);
        #1;
        take_b(0);

        // Read with RD_WAIT=3: rvalid first high after edge T+4, held while rready low.
        model_read(BASE + 32'h10);
        araddr  = BASE + 32'h10;
        arvalid = 1'b1;
        @(negedge clk);
        chk("t4_arready", arready, 1);
        @(posedge clk);
        #1 arvalid = 1'b0;
        for (int k = 1; k <= RDW; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t4_rvalid_wait", rvalid, 0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("t4_rvalid_rise", rvalid, 1);
        chk("t4_rdata_direct", rdata, 32'hDEAD_BEEF);
        repeat (5) @(posedge clk);
        #1;
        take_r(0);

        // W before AW, partial strobe.
        do_write(BASE + 32'h20, 32'h1122_3344, 4'hF, 0, 0, 0);
        do_write(BASE + 32'h20, 32'h0000_AAAA, 4'h3, 3, 0, 0);
        do_read(BASE + 32'h20, 0, 0);
        chk("t2_model_merge", model_mem[8], 32'h1122_AAAA);

        // Out of range write and read, then word 0 must be intact.
        do_write(BASE + 32'(DEPTH * 4), 32'hCAFE_F00D, 4'hF, 0, 0, 0);
        do_read(BASE + 32'(DEPTH * 4), 0, 0);
        do_read(BASE, 0, 0);
        do_read(BASE - 32'd4, 0, 1);

        // bready held low: second AW/W accepted, second commit waits for first B.
        bready = 1'b0;
        d1 = $urandom;
        d2 = $urandom;
        model_write(BASE + 32'h30, d1, 4'hF);
        fork
            send_aw(BASE + 32'h30);
            send_w(d1, 4'hF);
        join
        fork
            send_aw(BASE + 32'h34);
            send_w(d2, 4'hF);
        join
        do_read(BASE + 32'h34, 0, 0);
        model_write(BASE + 32'h34, d2, 4'hF);
        @(negedge clk);
        chk("t5_bvalid_pending", bvalid, 1);
        @(posedge clk);
        #1 bready = 1'b1;
        @(negedge clk);
        chk("t5_first_b", bvalid, 1);
        @(posedge clk);
        @(negedge clk);
        chk("t5_second_commit_waits", bvalid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("t5_second_commit", bvalid, 1);
        @(posedge clk);
        #1 bready = 1'b0;
        do_read(BASE + 32'h30, 0, 0);
        do_read(BASE + 32'h34, 0, 0);

        // Reset while B pending, a write held and a read in R_WAIT.
        old44 = model_mem[17];
        model_write(BASE + 32'h40, 32'h5A5A_0F0F, 4'hF);
        fork
            send_aw(BASE + 32'h40);
            send_w(32'h5A5A_0F0F, 4'hF);
        join
        repeat (2) @(posedge clk);
        #1;
        fork
            send_aw(BASE + 32'h44);
            send_w(~old44, 4'hF);
        join
        send_ar(BASE + 32'h08);
        @(posedge clk);
        #1 reset = 1'b1;
        exp_b.delete();
        exp_rdata.delete();
        exp_rresp.delete();
        @(posedge clk);
        @(negedge clk);
        chk("t6_bvalid", bvalid, 0);
        chk("t6_rvalid", rvalid, 0);
        chk("t6_awready", awready, 0);
        chk("t6_arready", arready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_awready_rel", awready, 1);
        chk("t6_wready_rel", wready, 1);
        chk("t6_arready_rel", arready, 1);
        @(posedge clk);
        #1 bready = 1'b1;
        rready = 1'b1;
        repeat (10) @(posedge clk);
        #1 bready = 1'b0;
        rready = 1'b0;
        do_read(BASE + 32'h44, 0, 0);
        do_read(BASE + 32'h40, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            int          pick;
            pick = $urandom_range(0, 7);
            if (pick == 0) a = BASE + 32'(DEPTH * 4) + ($urandom_range(0, 63) << 2);
            else if (pick == 1) a = BASE - 32'd4 - ($urandom_range(0, 15) << 2);
            else a = BASE + ($urandom_range(0, DEPTH - 1) << 2) + $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        repeat (5) @(posedge clk);
        chk("end_exp_b_empty", exp_b.size(), 0);
        chk("end_exp_r_empty", exp_rdata.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
